// File: rtl/ili9341_spi_rx_if.sv
// SPI bus plus decoded byte/pixel streams of the ILI9341 receive model.
// master = bus driver/observer (bench), slave = ili9341_spi_rx.
interface ili9341_spi_rx_if #(parameter int COORD_W = 9);
  logic               spi_sclk;
  logic               spi_cs;
  logic               spi_dc;
  logic               spi_mosi;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_dc;
  logic               pixel_valid;
  logic [15:0]        pixel_data;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;

  modport master (
    output spi_sclk, spi_cs, spi_dc, spi_mosi,
    input  byte_valid, byte_data, byte_dc, pixel_valid, pixel_data, pixel_x, pixel_y
  );

  modport slave (
    input  spi_sclk, spi_cs, spi_dc, spi_mosi,
    output byte_valid, byte_data, byte_dc, pixel_valid, pixel_data, pixel_x, pixel_y
  );
endinterface

// File: rtl/ili9341_spi_rx.sv
// ILI9341 4-wire SPI receiver: oversampled bit capture, command decoder, pixel cursor.
// Optional ILI9341_RX_STATS_EN adds saturating cmd_count / abort_count outputs.
module ili9341_spi_rx #(
  parameter int WIDTH       = 240,
  parameter int HEIGHT      = 320,
  parameter int COORD_W     = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  ili9341_spi_rx_if.slave    bus,
  output logic [COORD_W-1:0] col_start,
  output logic [COORD_W-1:0] col_end,
  output logic [COORD_W-1:0] page_start,
  output logic [COORD_W-1:0] page_end,
  output logic [7:0]         madctl,
  output logic [7:0]         colmod,
  output logic               sleep_out,
  output logic               display_on,
  output logic               cmd_err
`ifdef ILI9341_RX_STATS_EN
  ,
  output logic [15:0]        cmd_count,
  output logic [15:0]        abort_count
`endif
);

  // state    | meaning
  // IDLE     | no command pending, data bytes ignored
  // CASET_P  | collecting column window params SH SL EH EL
  // PASET_P  | collecting page window params SH SL EH EL
  // RAMWR    | pairing data bytes into RGB565 pixels
  // MADCTL_P | next data byte is madctl
  // COLMOD_P | next data byte is colmod
  // SKIP     | ignore data until next command
  typedef enum logic [2:0] {IDLE, CASET_P, PASET_P, RAMWR, MADCTL_P, COLMOD_P, SKIP} state_t;

  localparam logic [15:0]        WIDTH16  = 16'(WIDTH);
  localparam logic [15:0]        HEIGHT16 = 16'(HEIGHT);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(HEIGHT - 1);

  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, dc_sr, mosi_sr;
  logic                   sclk_q;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;
  logic                   sclk_s, cs_s, dc_s, mosi_s, rise;

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign dc_s   = dc_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_q;

  // cs synchroniser resets to idle-high so a reset never fakes a selected bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr        <= '0;
      cs_sr          <= '1;
      dc_sr          <= '0;
      mosi_sr        <= '0;
      sclk_q         <= 1'b0;
      bit_cnt        <= '0;
      shift          <= '0;
      bus.byte_valid <= 1'b0;
      bus.byte_data  <= '0;
      bus.byte_dc    <= 1'b0;
    end else begin
      sclk_sr        <= {sclk_sr[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sr          <= {cs_sr[SYNC_STAGES-2:0], bus.spi_cs};
      dc_sr          <= {dc_sr[SYNC_STAGES-2:0], bus.spi_dc};
      mosi_sr        <= {mosi_sr[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_q         <= sclk_s;
      bus.byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shift   <= {shift[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          bus.byte_valid <= 1'b1;
          bus.byte_data  <= {shift, mosi_s};
          bus.byte_dc    <= dc_s;
        end
      end
    end
  end

  state_t             state;
  logic [1:0]         pcnt;
  logic [7:0]         sh, sl, eh, hi;
  logic               odd;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [15:0]        par_start, par_end;
  logic               col_ok, row_ok;

  always_comb begin
    par_start = {sh, sl};
    par_end   = {eh, bus.byte_data};
    col_ok    = (par_start <= par_end) && (par_end < WIDTH16);
    row_ok    = (par_start <= par_end) && (par_end < HEIGHT16);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pcnt            <= '0;
      sh              <= '0;
      sl              <= '0;
      eh              <= '0;
      hi              <= '0;
      odd             <= 1'b0;
      cur_x           <= '0;
      cur_y           <= '0;
      col_start       <= '0;
      col_end         <= COL_LAST;
      page_start      <= '0;
      page_end        <= ROW_LAST;
      madctl          <= 8'h00;
      colmod          <= 8'h66;
      sleep_out       <= 1'b0;
      display_on      <= 1'b0;
      cmd_err         <= 1'b0;
      bus.pixel_valid <= 1'b0;
      bus.pixel_data  <= '0;
      bus.pixel_x     <= '0;
      bus.pixel_y     <= '0;
    end else begin
      bus.pixel_valid <= 1'b0;
      cmd_err         <= 1'b0;
      if (bus.byte_valid && !bus.byte_dc) begin
        pcnt <= '0;
        odd  <= 1'b0;
        case (bus.byte_data)
          8'h2A: state <= CASET_P;
          8'h2B: state <= PASET_P;
          8'h2C: begin state <= RAMWR; cur_x <= col_start; cur_y <= page_start; end
          8'h36: state <= MADCTL_P;
          8'h3A: state <= COLMOD_P;
          8'h11: begin sleep_out  <= 1'b1; state <= IDLE; end
          8'h10: begin sleep_out  <= 1'b0; state <= IDLE; end
          8'h29: begin display_on <= 1'b1; state <= IDLE; end
          8'h28: begin display_on <= 1'b0; state <= IDLE; end
          8'h01: begin
            state          <= IDLE;
            cur_x          <= '0;
            cur_y          <= '0;
            col_start      <= '0;
            col_end        <= COL_LAST;
            page_start     <= '0;
            page_end       <= ROW_LAST;
            madctl         <= 8'h00;
            colmod         <= 8'h66;
            sleep_out      <= 1'b0;
            display_on     <= 1'b0;
            bus.pixel_data <= '0;
            bus.pixel_x    <= '0;
            bus.pixel_y    <= '0;
          end
          8'h00:   state <= IDLE;
          default: state <= SKIP;
        endcase
      end else if (bus.byte_valid) begin
        case (state)
          CASET_P, PASET_P: begin
            pcnt <= pcnt + 2'd1;
            case (pcnt)
              2'd0: sh <= bus.byte_data;
              2'd1: sl <= bus.byte_data;
              2'd2: eh <= bus.byte_data;
              default: begin
                state <= SKIP;
                if (state == CASET_P) begin
                  if (col_ok) begin
                    col_start <= COORD_W'(par_start);
                    col_end   <= COORD_W'(par_end);
                  end else cmd_err <= 1'b1;
                end else begin
                  if (row_ok) begin
                    page_start <= COORD_W'(par_start);
                    page_end   <= COORD_W'(par_end);
                  end else cmd_err <= 1'b1;
                end
              end
            endcase
          end
          MADCTL_P: begin madctl <= bus.byte_data; state <= SKIP; end
          COLMOD_P: begin colmod <= bus.byte_data; state <= SKIP; end
          RAMWR: begin
            if (!odd) begin
              hi  <= bus.byte_data;
              odd <= 1'b1;
            end else begin
              odd             <= 1'b0;
              bus.pixel_valid <= 1'b1;
              bus.pixel_data  <= {hi, bus.byte_data};
              bus.pixel_x     <= cur_x;
              bus.pixel_y     <= cur_y;
              // advance row-major inside the window, wrapping at the bottom-right corner
              if (cur_x == col_end) begin
                cur_x <= col_start;
                cur_y <= (cur_y == page_end) ? page_start : cur_y + 1'b1;
              end else begin
                cur_x <= cur_x + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ILI9341_RX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_count   <= '0;
      abort_count <= '0;
    end else begin
      if (bus.byte_valid && !bus.byte_dc && cmd_count != 16'hFFFF)
        cmd_count <= cmd_count + 16'd1;
      if (cs_s && bit_cnt != 3'd0 && abort_count != 16'hFFFF)
        abort_count <= abort_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ili9341_spi_rx.sv
// Self-checking bench for ili9341_spi_rx: directed scenarios plus randomized windows/pixels
// checked against a byte-level behavioural model.
module tb_ili9341_spi_rx;
  localparam int WIDTH  = 240;
  localparam int HEIGHT = 320;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ili9341_spi_rx_if #(.COORD_W(9)) bus();
  logic [8:0] col_start, col_end, page_start, page_end;
  logic [7:0] madctl, colmod;
  logic       sleep_out, display_on, cmd_err;
`ifdef ILI9341_RX_STATS_EN
  logic [15:0] cmd_count, abort_count;
`endif

  ili9341_spi_rx #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COORD_W(9), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .col_start(col_start), .col_end(col_end), .page_start(page_start), .page_end(page_end),
    .madctl(madctl), .colmod(colmod), .sleep_out(sleep_out), .display_on(display_on),
    .cmd_err(cmd_err)
`ifdef ILI9341_RX_STATS_EN
    , .cmd_count(cmd_count), .abort_count(abort_count)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic [8:0]  x;
    logic [8:0]  y;
  } pix_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_bv = -100;
  int err_seen = 0;
  pix_t       got_pix[$], exp_pix[$];
  int         got_lat[$];
  logic [8:0] got_bytes[$], exp_bytes[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pixel_valid) begin
        got_pix.push_back({bus.pixel_data, bus.pixel_x, bus.pixel_y});
        got_lat.push_back(cyc - last_bv);
      end
      if (bus.byte_valid) begin
        got_bytes.push_back({bus.byte_dc, bus.byte_data});
        last_bv = cyc;
      end
      if (cmd_err) err_seen++;
    end
  end

  // ---------------- behavioural model (byte level) ----------------
  int m_cs, m_ce, m_ps, m_pe, m_mad, m_colmod, m_sleep, m_disp;
  int m_cmd, m_n, m_hi, m_x0, m_y0, m_wx, m_wy;
  int m_p[4];
  int m_err = 0, m_cmds = 0, m_aborts = 0;

  function automatic void model_regs_reset();
    m_cs = 0; m_ce = WIDTH - 1; m_ps = 0; m_pe = HEIGHT - 1;
    m_mad = 0; m_colmod = 8'h66; m_sleep = 0; m_disp = 0;
    m_cmd = 0; m_n = 0;
  endfunction

  function automatic void model_byte(input logic dc, input logic [7:0] d);
    int s, e, idx;
    pix_t p;
    exp_bytes.push_back({dc, d});
    if (!dc) begin
      m_cmds++;
      m_cmd = int'(d);
      m_n = 0;
      case (d)
        8'h11: m_sleep = 1;
        8'h10: m_sleep = 0;
        8'h29: m_disp = 1;
        8'h28: m_disp = 0;
        8'h01: model_regs_reset();
        8'h2C: begin m_x0 = m_cs; m_y0 = m_ps; m_wx = m_ce - m_cs + 1; m_wy = m_pe - m_ps + 1; end
        default: ;
      endcase
    end else begin
      if ((m_cmd == 8'h2A || m_cmd == 8'h2B) && m_n < 4) begin
        m_p[m_n] = int'(d);
        if (m_n == 3) begin
          s = m_p[0] * 256 + m_p[1];
          e = m_p[2] * 256 + m_p[3];
          if (s > e || e >= ((m_cmd == 8'h2A) ? WIDTH : HEIGHT)) m_err++;
          else if (m_cmd == 8'h2A) begin m_cs = s; m_ce = e; end
          else begin m_ps = s; m_pe = e; end
        end
      end else if (m_cmd == 8'h36 && m_n == 0) m_mad = int'(d);
      else if (m_cmd == 8'h3A && m_n == 0) m_colmod = int'(d);
      else if (m_cmd == 8'h2C) begin
        if (m_n % 2 == 0) m_hi = int'(d);
        else begin
          idx = m_n / 2;
          p.data = 16'(m_hi * 256 + int'(d));
          p.x = 9'(m_x0 + idx % m_wx);
          p.y = 9'(m_y0 + (idx / m_wx) % m_wy);
          exp_pix.push_back(p);
        end
      end
      if (m_n < 1000000) m_n++;
    end
  endfunction

  function automatic void clear_queues();
    got_pix.delete(); exp_pix.delete(); got_lat.delete();
    got_bytes.delete(); exp_bytes.delete();
  endfunction

  // ---------------- bus driving ----------------
  task automatic spi_bits(input logic dc, input logic [7:0] d, input int n);
    bus.spi_dc = dc;
    bus.spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_mosi = d[i];
      repeat (3) @(negedge clk);
      bus.spi_sclk = 1'b1;
      repeat (3) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
    repeat (3) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] d);
    spi_bits(dc, d, 8);
    model_byte(dc, d);
  endtask

  task automatic send_window(input logic [7:0] cmd, input int s, input int e);
    send_byte(1'b0, cmd);
    send_byte(1'b1, 8'(s >> 8)); send_byte(1'b1, 8'(s));
    send_byte(1'b1, 8'(e >> 8)); send_byte(1'b1, 8'(e));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (bus.byte_valid !== 1'b0) begin errors++; $display("FAIL rst_byte_valid got %0b want 0", bus.byte_valid); end
    checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL rst_pixel_valid got %0b want 0", bus.pixel_valid); end
    checks++; if ({bus.byte_data, bus.pixel_data, bus.pixel_x, bus.pixel_y} !== '0) begin errors++; $display("FAIL rst_data got %h %h %0d %0d want 0", bus.byte_data, bus.pixel_data, bus.pixel_x, bus.pixel_y); end
    checks++; if (col_start !== 9'd0 || col_end !== 9'd239) begin errors++; $display("FAIL rst_col got %0d..%0d want 0..239", col_start, col_end); end
    checks++; if (page_start !== 9'd0 || page_end !== 9'd319) begin errors++; $display("FAIL rst_page got %0d..%0d want 0..319", page_start, page_end); end
    checks++; if (madctl !== 8'h00 || colmod !== 8'h66) begin errors++; $display("FAIL rst_madctl_colmod got %h %h want 00 66", madctl, colmod); end
    checks++; if (sleep_out !== 1'b0 || display_on !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b%b want 000", sleep_out, display_on, cmd_err); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clear_queues();
    send_byte(1'b0, 8'h3A); send_byte(1'b1, 8'h55);
    checks++; if (colmod !== 8'h55) begin errors++; $display("FAIL colmod_set got %h want 55", colmod); end
    // reset in the middle of a byte
    bus.spi_cs = 1'b0; bus.spi_dc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.spi_mosi = 1'(i & 1);
      repeat (3) @(negedge clk); bus.spi_sclk = 1'b1;
      repeat (3) @(negedge clk); bus.spi_sclk = 1'b0;
    end
    rst = 1'b1;
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (colmod !== 8'h66) begin errors++; $display("FAIL midbyte_rst_colmod got %h want 66", colmod); end
    rst = 1'b0;
    model_regs_reset();
    m_cmds = 0; m_aborts = 0; m_err = 0; err_seen = 0;
    clear_queues();
    repeat (4) @(negedge clk);
    send_byte(1'b0, 8'h29);
    checks++; if (got_bytes.size() != 1 || got_bytes[0] !== 9'h029) begin errors++; $display("FAIL post_rst_byte got n=%0d first=%h want n=1 029", got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 9'h1FF); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL post_rst_display_on got %b want 1", display_on); end
  endtask

  task automatic test_caset();
    clear_queues();
    err_seen = 0;
    send_window(8'h2A, 10, 19);
    checks++; if (col_start !== 9'd10 || col_end !== 9'd19) begin errors++; $display("FAIL caset_window got %0d..%0d want 10..19", col_start, col_end); end
    checks++; if (err_seen != 0 || got_pix.size() != 0) begin errors++; $display("FAIL caset_side_effects got err=%0d pix=%0d want 0 0", err_seen, got_pix.size()); end
  endtask

  task automatic test_pixels();
    logic [7:0] data_bytes[10];
    pix_t want[5];
    data_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF, 8'h12, 8'h34};
    want = '{{16'hF800, 9'd10, 9'd5}, {16'h07E0, 9'd11, 9'd5}, {16'h001F, 9'd10, 9'd6},
             {16'hFFFF, 9'd11, 9'd6}, {16'h1234, 9'd10, 9'd5}};
    send_window(8'h2A, 10, 11);
    send_window(8'h2B, 5, 6);
    clear_queues();
    send_byte(1'b0, 8'h2C);
    foreach (data_bytes[i]) send_byte(1'b1, data_bytes[i]);
    checks++; if (got_pix.size() != 5) begin errors++; $display("FAIL pix_count got %0d want 5", got_pix.size()); end
    for (int i = 0; i < 5 && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== want[i] || got_lat[i] != 1)
        begin errors++; $display("FAIL pix_%0d got %h@(%0d,%0d) lat %0d want %h@(%0d,%0d) lat 1", i, got_pix[i].data, got_pix[i].x, got_pix[i].y, got_lat[i], want[i].data, want[i].x, want[i].y); end
    end
    send_byte(1'b0, 8'h00);
  endtask

  task automatic test_cs_abort();
    send_byte(1'b0, 8'h28);
    clear_queues();
    spi_bits(1'b0, 8'hA5, 5);
    m_aborts++;
    send_byte(1'b0, 8'h29);
    checks++; if (got_bytes.size() != 1 || got_bytes[0] !== 9'h029) begin errors++; $display("FAIL abort_bytes got n=%0d want n=1 029", got_bytes.size()); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL abort_display_on got %b want 1", display_on); end
`ifdef ILI9341_RX_STATS_EN
    checks++; if (abort_count !== 16'(m_aborts)) begin errors++; $display("FAIL abort_count got %0d want %0d", abort_count, m_aborts); end
`endif
  endtask

  task automatic test_caset_reject();
    err_seen = 0;
    send_window(8'h2A, 0, 239);
    checks++; if (err_seen != 0 || col_end !== 9'd239) begin errors++; $display("FAIL caset_edge_ok got err=%0d end=%0d want 0 239", err_seen, col_end); end
    send_window(8'h2A, 0, 240);
    send_window(8'h2A, 20, 10);
    send_window(8'h2B, 0, 320);
    checks++; if (err_seen != 3) begin errors++; $display("FAIL reject_err_pulses got %0d want 3", err_seen); end
    checks++; if (col_start !== 9'd0 || col_end !== 9'd239) begin errors++; $display("FAIL reject_col got %0d..%0d want 0..239", col_start, col_end); end
    checks++; if (page_start !== 9'd5 || page_end !== 9'd6) begin errors++; $display("FAIL reject_page got %0d..%0d want 5..6", page_start, page_end); end
  endtask

  task automatic test_regs_reset();
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h29);
    send_byte(1'b0, 8'h36); send_byte(1'b1, 8'h48);
    checks++; if (sleep_out !== 1'b1 || display_on !== 1'b1 || madctl !== 8'h48) begin errors++; $display("FAIL regs_set got %b %b %h want 1 1 48", sleep_out, display_on, madctl); end
    send_byte(1'b0, 8'h01);
    checks++; if (sleep_out !== 1'b0 || display_on !== 1'b0 || madctl !== 8'h00 || colmod !== 8'h66) begin errors++; $display("FAIL swreset_regs got %b %b %h %h want 0 0 00 66", sleep_out, display_on, madctl, colmod); end
    checks++; if (col_start !== 9'd0 || col_end !== 9'd239 || page_start !== 9'd0 || page_end !== 9'd319) begin errors++; $display("FAIL swreset_window got %0d..%0d %0d..%0d", col_start, col_end, page_start, page_end); end
`ifdef ILI9341_RX_STATS_EN
    checks++; if (cmd_count !== 16'(m_cmds)) begin errors++; $display("FAIL cmd_count got %0d want %0d", cmd_count, m_cmds); end
`endif
  endtask

  task automatic test_random();
    int s, e, npairs, err0, merr0;
    for (int it = 0; it < 8; it++) begin
      clear_queues();
      err0 = err_seen; merr0 = m_err;
      s = $urandom_range(0, 245); e = s + $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) e = s - 1;
      send_window(8'h2A, s, e);
      s = $urandom_range(0, 325); e = s + $urandom_range(0, 2);
      send_window(8'h2B, s, e);
      send_byte(1'b0, 8'h36); send_byte(1'b1, 8'($urandom));
      send_byte(1'b0, 8'h3A); send_byte(1'b1, 8'($urandom)); send_byte(1'b1, 8'($urandom));
      send_byte(1'b0, 8'h2C);
      npairs = $urandom_range(1, 10);
      for (int k = 0; k < 2 * npairs; k++) send_byte(1'b1, 8'($urandom));
      if ($urandom_range(0, 1) == 1) send_byte(1'b1, 8'($urandom));
      send_byte(1'b0, ($urandom_range(0, 1) == 1) ? 8'h55 : 8'h00);
      send_byte(1'b1, 8'($urandom));
      checks++; if (got_pix.size() != exp_pix.size()) begin errors++; $display("FAIL rnd%0d_pix_count got %0d want %0d", it, got_pix.size(), exp_pix.size()); end
      for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
        checks++;
        if (got_pix[i] !== exp_pix[i] || got_lat[i] != 1)
          begin errors++; $display("FAIL rnd%0d_pix%0d got %h@(%0d,%0d) lat %0d want %h@(%0d,%0d) lat 1", it, i, got_pix[i].data, got_pix[i].x, got_pix[i].y, got_lat[i], exp_pix[i].data, exp_pix[i].x, exp_pix[i].y); end
      end
      checks++; if (got_bytes != exp_bytes) begin errors++; $display("FAIL rnd%0d_bytes got n=%0d want n=%0d", it, got_bytes.size(), exp_bytes.size()); end
      checks++; if (err_seen - err0 != m_err - merr0) begin errors++; $display("FAIL rnd%0d_cmd_err got %0d want %0d", it, err_seen - err0, m_err - merr0); end
      checks++;
      if (col_start !== 9'(m_cs) || col_end !== 9'(m_ce) || page_start !== 9'(m_ps) || page_end !== 9'(m_pe))
        begin errors++; $display("FAIL rnd%0d_window got %0d..%0d %0d..%0d want %0d..%0d %0d..%0d", it, col_start, col_end, page_start, page_end, m_cs, m_ce, m_ps, m_pe); end
      checks++; if (madctl !== 8'(m_mad) || colmod !== 8'(m_colmod)) begin errors++; $display("FAIL rnd%0d_regs got %h %h want %h %h", it, madctl, colmod, m_mad, m_colmod); end
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.spi_sclk = 1'b0; bus.spi_cs = 1'b1; bus.spi_dc = 1'b0; bus.spi_mosi = 1'b0;
    model_regs_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_caset();
    test_pixels();
    test_cs_abort();
    test_caset_reject();
    test_regs_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
